alu_tmr_fault_ctrl: RTL and testbench

- Controller for the triplicated ALU and its majority voters.
- Consumes per-lane disagreement flags produced by comparing each lane's result/comparison/ready against the vote.
- Stalls EX and sequences bounded re-execution on detected faults.
- Keeps saturating per-lane error counters, permanently masks a lane once it is deemed hard-faulty, and escalates to a sticky FATAL state when no trustworthy majority remains.

---
 rtl/alu_tmr_fault_ctrl.sv | 129 ++++++++++++
 tb/tb_alu_tmr_fault_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_tmr_fault_ctrl.sv
// alu_tmr_fault_ctrl: fault controller for a triplicated ALU and its majority voters
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   alu_valid_i      ALU result consumed this cycle
//   lane_err_i[2:0]  per-lane disagreement with the voted value
//   no_majority_i    all three lanes differ pairwise
//   clear_i          synchronous clear of counters, lane mask and FATAL
//   stall_o          hold EX stage
//   retry_o          one-cycle pulse to re-issue the held operation
//   lane_disable_o   sticky per-lane mask toward the voters
//   fault_irq_o      one-cycle pulse per fault detection
//   fatal_o          sticky unrecoverable-fault flag
//   err_cnt_o        saturating per-lane error counters, lane i at [i*CNT_W +: CNT_W]
//   state_o          MONITOR=0, RETRY=1, CHECK=2, FATAL=3
module alu_tmr_fault_ctrl #(
  parameter int CNT_W        = 8,
  parameter int THRESH       = 4,
  parameter int MAX_RETRY    = 2,
  parameter int RETRY_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid_i,
  input  logic [2:0]         lane_err_i,
  input  logic               no_majority_i,
  input  logic               clear_i,
  output logic               stall_o,
  output logic               retry_o,
  output logic [2:0]         lane_disable_o,
  output logic               fault_irq_o,
  output logic               fatal_o,
  output logic [3*CNT_W-1:0] err_cnt_o,
  output logic [1:0]         state_o
);
  typedef enum logic [1:0] {MONITOR = 2'd0, RETRY = 2'd1, CHECK = 2'd2, FATAL = 2'd3} state_e;
  localparam int RC_W = $clog2(MAX_RETRY + 1);
  localparam int HC_W = $clog2(RETRY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR_M1  = CNT_W'(THRESH - 1);
  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(MAX_RETRY);
  localparam logic [HC_W-1:0]  HC_LAST = HC_W'(RETRY_CYCLES - 1);
  state_e                  state_q, state_d;
  logic [2:0]              dis_q, dis_d;
  logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [RC_W-1:0]         rc_q, rc_d;
  logic [HC_W-1:0]         hc_q, hc_d;
  logic [2:0]              eff;
  logic                    multi, err, det, single, at_thr;
  assign eff = lane_err_i & ~dis_q;
  // With a lane already masked only two voters remain, so any disagreement leaves no majority.
  assign multi  = no_majority_i | (eff[0] & eff[1]) | (eff[0] & eff[2]) | (eff[1] & eff[2])
                | (|eff & |dis_q);
  assign err    = alu_valid_i & (|eff | no_majority_i);
  assign det    = ~clear_i & err & (state_q == MONITOR || state_q == CHECK);
  assign single = det & ~multi;
  always_comb begin
    state_d = state_q;
    dis_d   = dis_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    hc_d    = hc_q;
    at_thr  = 1'b0;
    // eff is one-hot whenever single holds
    for (int i = 0; i < 3; i++)
      if (single && eff[i]) begin
        cnt_d[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + 1'b1;
        at_thr   = cnt_q[i] >= THR_M1;
      end
    case (state_q)
      MONITOR:
        if (det) begin
          if (single && at_thr) dis_d = dis_q | eff;
          else begin
            rc_d    = RC_W'(1);
            hc_d    = '0;
            state_d = RETRY;
          end
        end
      RETRY:
        if (hc_q == HC_LAST) state_d = CHECK;
        else hc_d = hc_q + 1'b1;
      CHECK:
        if (det) begin
          if (rc_q != RC_MAX) begin
            rc_d    = rc_q + 1'b1;
            hc_d    = '0;
            state_d = RETRY;
          end else if (!multi) begin
            dis_d   = dis_q | eff;
            rc_d    = '0;
            state_d = MONITOR;
          end else state_d = FATAL;
        end else if (alu_valid_i) begin
          rc_d    = '0;
          state_d = MONITOR;
        end
      FATAL: ;
    endcase
    if (clear_i) begin
      state_d = MONITOR;
      dis_d   = '0;
      cnt_d   = '0;
      rc_d    = '0;
      hc_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= MONITOR;
      dis_q   <= '0;
      cnt_q   <= '0;
      rc_q    <= '0;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      dis_q   <= dis_d;
      cnt_q   <= cnt_d;
      rc_q    <= rc_d;
      hc_q    <= hc_d;
    end
  // A clean result in CHECK releases the stall in the same cycle it is consumed.
  assign stall_o        = state_q == RETRY || state_q == FATAL || (state_q == CHECK && !(alu_valid_i && !err));
  assign retry_o        = state_q == RETRY && hc_q == '0;
  assign fault_irq_o    = det;
  assign fatal_o        = state_q == FATAL;
  assign lane_disable_o = dis_q;
  assign err_cnt_o      = cnt_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_alu_tmr_fault_ctrl.sv
// tb_alu_tmr_fault_ctrl: directed-vector bench for alu_tmr_fault_ctrl
module tb_alu_tmr_fault_ctrl;
  logic clk = 0, rst_n = 0, valid = 0, nomaj = 0, clr = 0;
  logic [2:0] lerr = '0;
  logic stall, retry, irq, fatal;
  logic [2:0] dis;
  logic [23:0] cnt;
  logic [1:0] st;
  logic b_valid = 0;
  logic [2:0] b_lerr = '0;
  logic b_stall, b_retry, b_irq, b_fatal;
  logic [2:0] b_dis;
  logic [5:0] b_cnt;
  logic [1:0] b_st;
  int n_vec = 0, n_err = 0, pulses;
  always #5 clk = ~clk;
  alu_tmr_fault_ctrl dut (
    .clk(clk), .rst_n(rst_n), .alu_valid_i(valid), .lane_err_i(lerr), .no_majority_i(nomaj),
    .clear_i(clr), .stall_o(stall), .retry_o(retry), .lane_disable_o(dis), .fault_irq_o(irq),
    .fatal_o(fatal), .err_cnt_o(cnt), .state_o(st)
  );
  alu_tmr_fault_ctrl #(.CNT_W(2), .THRESH(3), .MAX_RETRY(4), .RETRY_CYCLES(1)) sat (
    .clk(clk), .rst_n(rst_n), .alu_valid_i(b_valid), .lane_err_i(b_lerr), .no_majority_i(1'b0),
    .clear_i(1'b0), .stall_o(b_stall), .retry_o(b_retry), .lane_disable_o(b_dis), .fault_irq_o(b_irq),
    .fatal_o(b_fatal), .err_cnt_o(b_cnt), .state_o(b_st)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] le, input logic nm);
    valid = v;
    lerr  = le;
    nomaj = nm;
    #1;
  endtask
  initial begin
    #12;
    chk("rst_state", st, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_dis", dis, 0);
    chk("rst_fatal", fatal, 0);
    @(negedge clk);
    rst_n = 1;
    tick;
    drive(1, 3'b010, 0);
    chk("tr_irq", irq, 1);
    chk("tr_stall0", stall, 0);
    tick;
    chk("tr_retry_state", st, 1);
    chk("tr_retry", retry, 1);
    chk("tr_stall1", stall, 1);
    chk("tr_cnt1", cnt[15:8], 1);
    drive(0, 3'b000, 0);
    tick;
    chk("tr_check_state", st, 2);
    chk("tr_retry_pulse", retry, 0);
    chk("tr_check_stall", stall, 1);
    drive(1, 3'b000, 0);
    chk("tr_clean_stall", stall, 0);
    tick;
    chk("tr_back_monitor", st, 0);
    pulses = 0;
    for (int i = 0; i < 12 && dis != 3'b001; i++) begin
      drive(1, 3'b001, 0);
      if (retry) pulses++;
      tick;
    end
    drive(0, 3'b000, 0);
    chk("per_pulses", pulses, 2);
    chk("per_dis", dis, 3'b001);
    chk("per_cnt0", cnt[7:0], 3);
    chk("per_state", st, 0);
    pulses = 0;
    for (int i = 0; i < 12 && st != 2'd3; i++) begin
      drive(1, 3'b010, 0);
      if (retry) pulses++;
      tick;
    end
    drive(0, 3'b000, 0);
    chk("dup_pulses", pulses, 2);
    chk("dup_fatal_state", st, 3);
    chk("dup_cnt1", cnt[15:8], 1);
    chk("dup_fatal", fatal, 1);
    clr = 1;
    tick;
    clr = 0;
    #1;
    chk("clr_state", st, 0);
    chk("clr_dis", dis, 0);
    chk("clr_cnt", cnt, 0);
    chk("clr_fatal", fatal, 0);
    chk("clr_stall", stall, 0);
    drive(0, 3'b011, 1);
    chk("idle_irq", irq, 0);
    tick;
    chk("idle_state", st, 0);
    for (int i = 0; i < 12 && st != 2'd3; i++) begin
      drive(1, 3'b111, 1);
      tick;
    end
    drive(0, 3'b000, 0);
    chk("nm_state", st, 3);
    chk("nm_cnt", cnt, 0);
    tick;
    tick;
    chk("nm_fatal_sticky", fatal, 1);
    chk("nm_stall_sticky", stall, 1);
    clr = 1;
    tick;
    clr = 0;
    #1;
    chk("nm_clr_state", st, 0);
    chk("nm_clr_fatal", fatal, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'b100, 0);
      chk("th_irq", irq, 1);
      tick;
      drive(0, 3'b000, 0);
      tick;
      drive(1, 3'b000, 0);
      tick;
      drive(0, 3'b000, 0);
    end
    chk("th_cnt3", cnt[23:16], 3);
    chk("th_state_pre", st, 0);
    drive(1, 3'b100, 0);
    chk("th_irq4", irq, 1);
    tick;
    chk("th_state", st, 0);
    chk("th_retry", retry, 0);
    chk("th_dis", dis, 3'b100);
    chk("th_cnt4", cnt[23:16], 4);
    drive(1, 3'b100, 0);
    chk("th_masked_irq", irq, 0);
    tick;
    chk("th_masked_state", st, 0);
    drive(0, 3'b000, 0);
    for (int i = 0; i < 20 && b_dis == 3'b000; i++) begin
      b_valid = 1;
      b_lerr  = 3'b010;
      tick;
    end
    b_valid = 0;
    b_lerr  = 3'b000;
    chk("sat_cnt", b_cnt[3:2], 3);
    chk("sat_dis", b_dis, 3'b010);
    chk("sat_state", b_st, 0);
    drive(1, 3'b001, 0);
    tick;
    drive(0, 3'b000, 0);
    chk("mid_state", st, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mr_state", st, 0);
    chk("mr_stall", stall, 0);
    chk("mr_cnt", cnt, 0);
    chk("mr_dis", dis, 0);
    chk("mr_sat_cnt", b_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    tick;
    chk("mr_after", st, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
